matrix_addsub_ctrl: RTL

Sequencing controller for the 5x5 matrix add/subtract datapath in the HPS-FPGA coprocessor. It accepts one command (add or subtract), streams operand A and then operand B in row by row over a valid/ready port, and drives the combinational add/sub datapath for one evaluation cycle. It registers the 200-bit result and overflow flag, then streams the result back out row by row. It sits between the HPS bridge command/data FIFOs and the datapath.

---
 rtl/matrix_pkg.sv | 34 +++
 rtl/matrix_row_buffer.sv | 53 +++++
 rtl/matrix_addsub_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/matrix_pkg.sv
// ============================================================================
// matrix_pkg : shared sizes, state encoding and opcodes for the 5x5 add/sub
//              sequencing controller.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 5;
  localparam int ROW_W  = DIM * ELEM_W;
  localparam int MAT_W  = DIM * ROW_W;
  localparam int CNT_W  = (DIM > 1) ? $clog2(DIM) : 1;

  typedef logic [CNT_W-1:0] row_idx_t;

  localparam row_idx_t LAST_ROW = row_idx_t'(DIM - 1);
  localparam row_idx_t PEN_ROW  = row_idx_t'((DIM > 1) ? DIM - 2 : 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    STORE  = 3'd4
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/matrix_row_buffer.sv
// ============================================================================
// matrix_row_buffer : full-matrix register with a row write port, a parallel
//                     load and a row read mux.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module matrix_row_buffer
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr_en,
  input  row_idx_t         i_wr_row,
  input  logic [ROW_W-1:0] i_wr_data,
  input  logic             i_ld_en,
  input  logic [MAT_W-1:0] i_ld_data,
  input  row_idx_t         i_rd_row,
  output logic [MAT_W-1:0] o_mat,
  output logic [ROW_W-1:0] o_rd_data
);

  logic [MAT_W-1:0] r_mat;

  // A parallel load wins over a row write; the controller never issues both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mat <= '0;
    end else if (i_ld_en) begin
      r_mat <= i_ld_data;
    end else if (i_wr_en) begin
      for (int r = 0; r < DIM; r++) begin
        if (i_wr_row == row_idx_t'(r)) begin
          r_mat[r*ROW_W +: ROW_W] <= i_wr_data;
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    for (int r = 0; r < DIM; r++) begin
      if (i_rd_row == row_idx_t'(r)) begin
        o_rd_data = r_mat[r*ROW_W +: ROW_W];
      end
    end
  end

  assign o_mat = r_mat;

endmodule

`default_nettype wire

// File: rtl/matrix_addsub_ctrl.sv
// ============================================================================
// matrix_addsub_ctrl : loads A and B row by row, runs the external add/sub
//                      datapath for one cycle and streams the result out.
// Option             : MATRIX_CTRL_ABORT_EN adds the 'abort' input.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module matrix_addsub_ctrl
  import matrix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
`ifdef MATRIX_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  input  logic             cmd_op,
  output logic             cmd_ready,
  input  logic             in_valid,
  input  logic [ROW_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_data,
  output logic             out_last,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy,
  output logic [MAT_W-1:0] dp_mat_a,
  output logic [MAT_W-1:0] dp_mat_b,
  output logic             dp_select,
  input  logic [MAT_W-1:0] dp_mat_out,
  input  logic             dp_overflow
);

  state_t   r_state;
  row_idx_t r_cnt;
  logic     r_op;
  logic     r_ovf;
  logic     r_cmd_ready;
  logic     r_in_ready;
  logic     r_out_valid;
  logic     r_out_last;
  logic     r_busy;

  logic             w_abort;
  logic             w_wr_a;
  logic             w_wr_b;
  logic             w_ld_res;
  logic [ROW_W-1:0] w_res_row;
  logic [ROW_W-1:0] w_a_rd_unused;
  logic [ROW_W-1:0] w_b_rd_unused;
  logic [MAT_W-1:0] w_res_mat_unused;

`ifdef MATRIX_CTRL_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  // Abort suppresses any same-cycle buffer update.
  assign w_wr_a   = (r_state == LOAD_A) && in_valid && !w_abort;
  assign w_wr_b   = (r_state == LOAD_B) && in_valid && !w_abort;
  assign w_ld_res = (r_state == EXEC) && !w_abort;

  matrix_row_buffer u_buf_a (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_wr_a),
    .i_wr_row  (r_cnt),
    .i_wr_data (in_data),
    .i_ld_en   (1'b0),
    .i_ld_data ({MAT_W{1'b0}}),
    .i_rd_row  (r_cnt),
    .o_mat     (dp_mat_a),
    .o_rd_data (w_a_rd_unused)
  );

  matrix_row_buffer u_buf_b (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (w_wr_b),
    .i_wr_row  (r_cnt),
    .i_wr_data (in_data),
    .i_ld_en   (1'b0),
    .i_ld_data ({MAT_W{1'b0}}),
    .i_rd_row  (r_cnt),
    .o_mat     (dp_mat_b),
    .o_rd_data (w_b_rd_unused)
  );

  matrix_row_buffer u_buf_res (
    .clk       (clk),
    .rst       (reset),
    .i_wr_en   (1'b0),
    .i_wr_row  ('0),
    .i_wr_data ({ROW_W{1'b0}}),
    .i_ld_en   (w_ld_res),
    .i_ld_data (dp_mat_out),
    .i_rd_row  (r_cnt),
    .o_mat     (w_res_mat_unused),
    .o_rd_data (w_res_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op        <= OP_ADD;
      r_ovf       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_abort) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_ready <= 1'b1;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op        <= cmd_op;
            r_cnt       <= '0;
            r_state     <= LOAD_A;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        LOAD_A: begin
          if (in_valid) begin
            if (r_cnt == LAST_ROW) begin
              r_cnt   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            if (r_cnt == LAST_ROW) begin
              r_cnt      <= '0;
              r_state    <= EXEC;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        EXEC: begin
          r_ovf       <= dp_overflow;
          r_state     <= STORE;
          r_out_valid <= 1'b1;
          r_out_last  <= (DIM == 1);
        end
        STORE: begin
          if (out_ready) begin
            if (r_cnt == LAST_ROW) begin
              r_cnt       <= '0;
              r_state     <= IDLE;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_out_last <= (r_cnt == PEN_ROW);
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_cmd_ready <= 1'b1;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign dp_select = r_op;
  // Result data and flag are only presented while a row is on offer.
  assign out_data  = r_out_valid ? w_res_row : '0;
  assign out_ovf   = r_out_valid & r_ovf;

endmodule

`default_nettype wire
